prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Boot-time program loader between a word-stream source (bench, UART or host port) and the unified instruction/data memory.
- Owns the memory write port while a program streams in, writes words to consecutive addresses from a base, then hands the memory back to the datapath.
- Releases the processor's reset only after the load completes.
- Generalises the hand-sequenced memory-fill/release flow into a parametrised, handshaked, checked block.

Parameters:
- DATA_W, 16, memory word width.
- ADDR_W, 16, memory address width.
- DEPTH, 1024, maximum words per load; words beyond this are an overflow.
- BASE_ADDR, 0, address of the first loaded word.
- RESET_HOLD, 4, cycles the CPU reset stays asserted after memory handover (>=1).

Ports:
- clk  in  1  system clock; all activity on posedge.
- reset  in  1  synchronous, active-high block reset.
- start  in  1  one-cycle pulse; begins a load.
- in_valid  in  1  stream word valid.
- in_data  in  DATA_W  stream word.
- in_last  in  1  marks the final program word; qualified by in_valid.
- in_ready  out  1  loader can accept a word this cycle.
- mem_sel  out  1  1 = loader drives the memory port; 0 = datapath (PC) drives it.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  DATA_W  write data.
- mem_we  out  1  write enable (the memory's read/write select).
- cpu_reset  out  1  reset to the controller and datapath.
- done  out  1  program loaded, CPU running.
- error  out  1  load failed (overflow or checksum).
- word_count  out  ADDR_W+1  words written in the current or last load.

Behaviour:
- Reset values: in_ready=0, mem_sel=1, mem_addr=BASE_ADDR, mem_wdata=0, mem_we=0, cpu_reset=1, done=0, error=0, word_count=0. State returns to IDLE.
- Reset asserted mid-load abandons the load. Memory keeps any words already written.
- States:
  - IDLE: mem_sel=1, cpu_reset=1, in_ready=0. start -> LOAD, clears word_count, error and done.
  - LOAD: in_ready=1. A word is accepted when in_valid && in_ready.
    - On accept: next cycle mem_we=1, mem_addr=BASE_ADDR+word_count, mem_wdata=in_data; word_count increments. mem_we lasts exactly one cycle per accepted word.
    - Back-to-back accepts give one write per cycle, so throughput is 1 word/clk.
    - Accept with in_last=1 -> CKSUM when LOADER_CKSUM_EN is defined, else DRAIN.
    - Accept when word_count==DEPTH -> ERROR. That word is not written (mem_we stays 0).
    - start during LOAD is ignored.
  - DRAIN: one cycle. The final write commits while mem_sel=1 and in_ready=0. -> HOLD.
  - HOLD: mem_sel=0, cpu_reset=1. Counts RESET_HOLD cycles, then -> RUN.
  - RUN: cpu_reset=0, done=1, mem_sel=0, in_ready=0. start -> LOAD for a reload. On that transition, cpu_reset=1, mem_sel=1 and done=0 are set in the same edge.
  - ERROR: error=1, cpu_reset=1, mem_sel=1, in_ready=0. Only start (-> LOAD) or reset exits.
- start arriving in the same cycle as reset: reset wins.
- word_count is held after DONE/ERROR for inspection.
- Address arithmetic is modulo 2^ADDR_W. Overflow detection uses DEPTH, not address wrap.

Optional Feature:
- Macro: LOADER_CKSUM_EN.
- Defined:
  - LOAD keeps a running modulo-2^DATA_W sum of every accepted program word.
  - After the in_last word, state CKSUM (in_ready=1) accepts exactly one extra word. That word is not written to memory.
  - If it equals the running sum -> DRAIN; otherwise -> ERROR.
  - in_last on the checksum word is ignored.
- Not defined: no CKSUM state and no sum register. The in_last word goes straight to DRAIN.

Decomposition:
- Shared package: the state encoding enum (IDLE, LOAD, CKSUM, DRAIN, HOLD, RUN, ERROR) and the default-width constants (word 16, address 16), both used by the processor top.
- One natural sub-module: loader_hold_ctr, a down-counter loaded with RESET_HOLD that pulses expire on reaching zero. Everything else stays inline.

Test Plan:
- Basic load: reset 3 cycles, start, stream 0xB010, 0xEA00, 0x0FFF (last) back-to-back. Required: writes to addresses 0, 1, 2 on consecutive cycles; mem_sel falls after the DRAIN cycle; cpu_reset falls RESET_HOLD=4 cycles later; done=1; word_count=3.
- Stall handling: in_valid toggles 1,0,0,1,1 with data 0x1111/0x2222/0x3333. Required: exactly 3 writes, no write on idle cycles, addresses contiguous from BASE_ADDR=0x0100.
- Overflow: DEPTH=4, stream 5 words. Required: 4 writes, fifth not written, error=1, cpu_reset stays 1, word_count=4.
- Checksum (macro on): stream 0x0001, 0x0002 (last) then 0x0003. Required: 2 writes, done=1. Repeat with checksum 0x0004 -> error=1, no handover.
- Reset mid-load: assert reset after 2 of 5 words. Required: all outputs at reset values next edge. A new start plus a 1-word load -> word_count=1, done=1.
- Reload from RUN: start in RUN. Required: same edge sets cpu_reset=1, mem_sel=1, done=0; a second program loads and the CPU is re-released.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared loader definitions: state encoding and default word/address widths,
// also consumed by the processor top.
package prog_loader_pkg;

  localparam int unsigned LOADER_WORD_W = 16;
  localparam int unsigned LOADER_ADDR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CKSUM,
    ST_DRAIN,
    ST_HOLD,
    ST_RUN,
    ST_ERROR
  } loader_state_t;

endpackage

// File: rtl/prog_loader_hold_ctr.sv
// Down-counter timing the CPU reset hold after memory handover; expire is
// high for the single cycle in which the count is about to reach zero.
module loader_hold_ctr #(
  parameter int unsigned HOLD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic expire
);

  localparam int unsigned CW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(HOLD);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  always_comb begin
    expire = (cnt == CW'(1));
  end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: streams words into memory, then releases CPU reset.
// Optional checksum word after the last program word: define LOADER_CKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned DATA_W     = LOADER_WORD_W,
  parameter int unsigned ADDR_W     = LOADER_ADDR_W,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned RESET_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  loader_state_t state;
  logic          accept;
  logic          hold_expire;
  logic          hold_load;

`ifdef LOADER_CKSUM_EN
  logic [DATA_W-1:0] sum;
`endif

  always_comb begin
    accept    = in_valid && in_ready;
    hold_load = (state == ST_DRAIN);
  end

  loader_hold_ctr #(
    .HOLD (RESET_HOLD)
  ) u_hold_ctr (
    .clk    (clk),
    .reset  (reset),
    .load   (hold_load),
    .expire (hold_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b0;
      mem_sel    <= 1'b1;
      mem_addr   <= BASE_C;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
`ifdef LOADER_CKSUM_EN
      sum        <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        // A reload from RUN or ERROR reclaims memory and re-asserts CPU reset on the same edge.
        ST_IDLE, ST_RUN, ST_ERROR: begin
          if (start) begin
            state      <= ST_LOAD;
            in_ready   <= 1'b1;
            mem_sel    <= 1'b1;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
`ifdef LOADER_CKSUM_EN
            sum        <= '0;
`endif
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (word_count == DEPTH_C) begin
              state    <= ST_ERROR;
              error    <= 1'b1;
              in_ready <= 1'b0;
            end else begin
              mem_we     <= 1'b1;
              mem_addr   <= BASE_C + word_count[ADDR_W-1:0];
              mem_wdata  <= in_data;
              word_count <= word_count + (ADDR_W + 1)'(1);
`ifdef LOADER_CKSUM_EN
              sum        <= sum + in_data;
              if (in_last) begin
                state <= ST_CKSUM;
              end
`else
              if (in_last) begin
                state    <= ST_DRAIN;
                in_ready <= 1'b0;
              end
`endif
            end
          end
        end
`ifdef LOADER_CKSUM_EN
        ST_CKSUM: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (in_data == sum) begin
              state <= ST_DRAIN;
            end else begin
              state <= ST_ERROR;
              error <= 1'b1;
            end
          end
        end
`endif
        ST_DRAIN: begin
          state   <= ST_HOLD;
          mem_sel <= 1'b0;
        end
        ST_HOLD: begin
          if (hold_expire) begin
            state     <= ST_RUN;
            cpu_reset <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: write scoreboard plus directed load scenarios.
module tb_prog_loader;

  localparam int DW         = 16;
  localparam int AW         = 16;
  localparam int DEPTH      = 4;
  localparam int BASE       = 'h0100;
  localparam int RESET_HOLD = 4;
`ifdef LOADER_CKSUM_EN
  localparam int SEL_LAG = 2;
`else
  localparam int SEL_LAG = 1;
`endif

  logic          clk = 1'b0;
  logic          reset, start, in_valid, in_last;
  logic [DW-1:0] in_data;
  logic          in_ready, mem_sel, mem_we, cpu_reset, done, error;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [AW:0]   word_count;

  always #5 clk = ~clk;

  prog_loader #(
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .DEPTH      (DEPTH),
    .BASE_ADDR  (BASE),
    .RESET_HOLD (RESET_HOLD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .mem_sel    (mem_sel),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0, first_we = -1, last_we = -1, sel_fall = -1, rst_fall = -1, nwrites = 0;
  logic [15:0] exp_addr[$], exp_data[$], wlog_addr[$], wlog_data[$], prog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic new_scenario();
    first_we = -1; last_we = -1; sel_fall = -1; rst_fall = -1; nwrites = 0;
    wlog_addr.delete(); wlog_data.delete();
  endtask

  // Every cycle: score writes against the expected queue and check handover rules.
  task automatic monitor();
    logic ps = 1'b1, pr = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (mem_we === 1'b1) begin
        nwrites++;
        last_we = cyc;
        if (first_we < 0) first_we = cyc;
        wlog_addr.push_back(mem_addr);
        wlog_data.push_back(mem_wdata);
        chk("write_expected", exp_addr.size() > 0, 1);
        if (exp_addr.size() > 0) begin
          chk("wr_addr", mem_addr, exp_addr.pop_front());
          chk("wr_data", mem_wdata, exp_data.pop_front());
        end
        chk("write_owns_mem", mem_sel, 1);
      end
      chk("done_vs_cpu_reset", done, !cpu_reset);
      if (!mem_sel) chk("ready_while_released", in_ready, 0);
      if (error) chk("error_keeps_reset", {cpu_reset, mem_sel}, 2'b11);
      if (ps && !mem_sel) sel_fall = cyc;
      if (pr && !cpu_reset) rst_fall = cyc;
      ps = mem_sel;
      pr = cpu_reset;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic l, input bit wr, input logic [15:0] a);
    bit acc = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = l;
    for (int i = 0; i < 16 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      if (acc && wr) begin
        exp_addr.push_back(a);
        exp_data.push_back(d);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("accept", acc, 1);
  endtask

  // Model: word k goes to BASE+k while k < DEPTH; word DEPTH overflows and is dropped.
  task automatic load_prog(input bit use_sum, input logic [15:0] ck);
    logic [15:0] s = '0;
    bit ovf = 1'b0;
    for (int k = 0; k < prog.size() && !ovf; k++) begin
      if (k < DEPTH) begin
        send(prog[k], k == prog.size() - 1, 1'b1, 16'(BASE + k));
        s += prog[k];
      end else begin
        send(prog[k], k == prog.size() - 1, 1'b0, 16'h0);
        ovf = 1'b1;
      end
    end
`ifdef LOADER_CKSUM_EN
    if (!ovf) send(use_sum ? s : ck, 1'b1, 1'b0, 16'h0);
`else
    if (use_sum && ck != s) s = ck;
`endif
  endtask

  task automatic wait_outcome();
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = done || error;
    end
    @(posedge clk); #1;
    chk("outcome_in_budget", seen, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_mem_sel"}, mem_sel, 1);
    chk({tag, "_mem_addr"}, mem_addr, BASE);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_cpu_reset"}, cpu_reset, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_word_count"}, word_count, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic back-to-back load
    new_scenario();
    pulse_start();
    prog = '{16'hB010, 16'hEA00, 16'h0FFF};
    load_prog(1'b1, 16'h0);
    wait_outcome();
    chk("basic_done", done, 1);
    chk("basic_error", error, 0);
    chk("basic_count", word_count, 3);
    chk("basic_nwrites", nwrites, 3);
    if (wlog_addr.size() == 3) begin
      chk("basic_a0", wlog_addr[0], 16'h0100);
      chk("basic_d0", wlog_data[0], 16'hB010);
      chk("basic_a1", wlog_addr[1], 16'h0101);
      chk("basic_d1", wlog_data[1], 16'hEA00);
      chk("basic_a2", wlog_addr[2], 16'h0102);
      chk("basic_d2", wlog_data[2], 16'h0FFF);
    end
    chk("basic_consecutive", last_we - first_we, 2);
    chk("basic_sel_lag", sel_fall - last_we, SEL_LAG);
    chk("basic_hold", rst_fall - sel_fall, RESET_HOLD);

    // Reload from RUN, with a stalled stream
    new_scenario();
    pulse_start();
    chk("reload_cpu_reset", cpu_reset, 1);
    chk("reload_mem_sel", mem_sel, 1);
    chk("reload_done", done, 0);
    chk("reload_count", word_count, 0);
    send(16'h1111, 1'b0, 1'b1, 16'h0100);
    repeat (2) begin @(posedge clk); #1; end
    send(16'h2222, 1'b0, 1'b1, 16'h0101);
`ifdef LOADER_CKSUM_EN
    send(16'h3333, 1'b1, 1'b1, 16'h0102);
    send(16'h6666, 1'b0, 1'b0, 16'h0);
`else
    send(16'h3333, 1'b1, 1'b1, 16'h0102);
`endif
    wait_outcome();
    chk("stall_nwrites", nwrites, 3);
    chk("stall_done", done, 1);
    chk("stall_count", word_count, 3);
    chk("stall_hold", rst_fall - sel_fall, RESET_HOLD);

    // Overflow: DEPTH+1 words
    new_scenario();
    pulse_start();
    prog = '{16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04, 16'h0A05};
    load_prog(1'b1, 16'h0);
    wait_outcome();
    repeat (3) begin @(posedge clk); #1; end
    chk("ovf_nwrites", nwrites, 4);
    chk("ovf_error", error, 1);
    chk("ovf_cpu_reset", cpu_reset, 1);
    chk("ovf_done", done, 0);
    chk("ovf_count", word_count, 4);
    chk("ovf_queue_empty", exp_addr.size(), 0);

`ifdef LOADER_CKSUM_EN
    new_scenario();
    pulse_start();
    chk("ck_error_cleared", error, 0);
    prog = '{16'h0001, 16'h0002};
    load_prog(1'b0, 16'h0003);
    wait_outcome();
    chk("ck_good_nwrites", nwrites, 2);
    chk("ck_good_done", done, 1);
    chk("ck_good_count", word_count, 2);

    new_scenario();
    pulse_start();
    load_prog(1'b0, 16'h0004);
    wait_outcome();
    repeat (6) begin @(posedge clk); #1; end
    chk("ck_bad_nwrites", nwrites, 2);
    chk("ck_bad_error", error, 1);
    chk("ck_bad_mem_sel", mem_sel, 1);
    chk("ck_bad_cpu_reset", cpu_reset, 1);
`endif

    // Reset mid-load, with start colliding with reset
    new_scenario();
    pulse_start();
    send(16'h5001, 1'b0, 1'b1, 16'h0100);
    send(16'h5002, 1'b0, 1'b1, 16'h0101);
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("midreset");
    reset = 1'b0; start = 1'b0;
    chk("midreset_nwrites", nwrites, 2);
    @(posedge clk); #1;
    chk("idle_in_ready", in_ready, 0);
    new_scenario();
    pulse_start();
    prog = '{16'h00AA};
    load_prog(1'b1, 16'h0);
    wait_outcome();
    chk("single_done", done, 1);
    chk("single_count", word_count, 1);
    chk("single_nwrites", nwrites, 1);
    chk("final_queue_empty", exp_addr.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
